// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: stage payload widths, field offsets and
// the skid-stage state encoding used by pipe_stage_reg.
package pipe_pkg;

  localparam int unsigned IF_ID_W  = 64;
  localparam int unsigned ID_EX_W  = 147;
  localparam int unsigned EX_MEM_W = 107;
  localparam int unsigned MEM_WB_W = 39;

  localparam int unsigned MEM_WB_RESULT_LSB   = 0;
  localparam int unsigned MEM_WB_ADDR_LSB     = 32;
  localparam int unsigned MEM_WB_REGWRITE_BIT = 37;
  localparam int unsigned MEM_WB_MEMTOREG_BIT = 38;

  typedef struct packed {
    logic        memtoreg;
    logic        regwrite;
    logic [4:0]  addr;
    logic [31:0] result;
  } mem_wb_t;

  // {skid_valid, main_valid}
  localparam logic [1:0] ST_EMPTY = 2'b00;
  localparam logic [1:0] ST_ONE   = 2'b01;
  localparam logic [1:0] ST_TWO   = 2'b11;

  function automatic logic [MEM_WB_W-1:0] pack_mem_wb(mem_wb_t f);
    return f;
  endfunction

endpackage

// File: rtl/pipe_stage_stats.sv
// Saturating stall / killed-bubble counters for pipe_stage_reg.
// Only instantiated when PIPE_STAGE_REG_STATS_EN is defined.
module pipe_stage_stats (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        kill,
  output logic [31:0] stall_cnt,
  output logic [15:0] flush_cnt
);

  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall && stall_cnt != '1)
        stall_cnt <= stall_cnt + 32'd1;
      if (kill && flush_cnt != '1)
        flush_cnt <= flush_cnt + 16'd1;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Parametrised inter-stage register with 2-entry skid buffer and flush.
// Optional counters enabled by defining PIPE_STAGE_REG_STATS_EN.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int unsigned        DATA_W       = MEM_WB_W,
  parameter logic [DATA_W-1:0]  RESET_VAL    = '0,
  parameter bit                 CLR_ON_FLUSH = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data
`ifdef PIPE_STAGE_REG_STATS_EN
  ,
  output logic [31:0]       stall_cnt,
  output logic [15:0]       flush_cnt
`endif
);

  logic              main_v;
  logic              skid_v;
  logic              rdy_q;
  logic [DATA_W-1:0] main_d;
  logic [DATA_W-1:0] skid_d;
  logic [1:0]        st;
  logic              accept;
  logic              drain;

  assign st     = {skid_v, main_v};
  assign accept = in_valid & rdy_q;
  assign drain  = main_v & out_ready;

  always_ff @(posedge clk) begin
    if (!rst) begin
      main_v <= 1'b0;
      skid_v <= 1'b0;
      rdy_q  <= 1'b1;
      main_d <= RESET_VAL;
      skid_d <= RESET_VAL;
    end else if (flush) begin
      main_v <= 1'b0;
      skid_v <= 1'b0;
      rdy_q  <= 1'b1;
      if (CLR_ON_FLUSH) begin
        main_d <= RESET_VAL;
        skid_d <= RESET_VAL;
      end
    end else begin
      unique case (1'b1)
        st == ST_EMPTY: begin
          if (accept) begin
            main_v <= 1'b1;
            main_d <= in_data;
          end
        end
        st == ST_ONE: begin
          if (accept && drain) begin
            main_d <= in_data;
          end else if (accept) begin
            skid_v <= 1'b1;
            skid_d <= in_data;
            rdy_q  <= 1'b0;
          end else if (drain) begin
            main_v <= 1'b0;
          end
        end
        st == ST_TWO: begin
          if (drain) begin
            main_d <= skid_d;
            skid_v <= 1'b0;
            rdy_q  <= 1'b1;
          end
        end
        default: begin
          main_v <= 1'b0;
          skid_v <= 1'b0;
          rdy_q  <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready  = rdy_q;
  assign out_valid = main_v;
  assign out_data  = main_d;

`ifdef PIPE_STAGE_REG_STATS_EN
  pipe_stage_stats u_stats (
    .clk       (clk),
    .rst       (rst),
    .stall     (main_v & ~out_ready),
    .kill      (flush & main_v),
    .stall_cnt (stall_cnt),
    .flush_cnt (flush_cnt)
  );
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: directed vector table, hand sequences and
// randomized traffic against a queue-based reference model.
module tb_pipe_stage_reg;
  import pipe_pkg::*;

  localparam int unsigned W = MEM_WB_W;
  localparam logic [W-1:0] RV_H = 39'h15A;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [W-1:0] in_data, out_data;

  logic         h_rst, h_flush, h_iv, h_ir, h_ov, h_ordy;
  logic [W-1:0] h_d, h_od;

`ifdef PIPE_STAGE_REG_STATS_EN
  logic [31:0] stall_cnt, h_stall_cnt;
  logic [15:0] flush_cnt, h_flush_cnt;
  longint      m_stall, m_flush;
`endif

  pipe_stage_reg dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
`ifdef PIPE_STAGE_REG_STATS_EN
    ,
    .stall_cnt (stall_cnt),
    .flush_cnt (flush_cnt)
`endif
  );

  pipe_stage_reg #(
    .DATA_W       (W),
    .RESET_VAL    (RV_H),
    .CLR_ON_FLUSH (1'b0)
  ) dut_h (
    .clk       (clk),
    .rst       (h_rst),
    .flush     (h_flush),
    .in_valid  (h_iv),
    .in_ready  (h_ir),
    .in_data   (h_d),
    .out_valid (h_ov),
    .out_ready (h_ordy),
    .out_data  (h_od)
`ifdef PIPE_STAGE_REG_STATS_EN
    ,
    .stall_cnt (h_stall_cnt),
    .flush_cnt (h_flush_cnt)
`endif
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference: the stage is a FIFO of at most two payloads.
  logic [W-1:0] mq[$];
  logic [W-1:0] mdata = '0;

  task automatic model_edge();
    bit acc, drn;
    acc = in_valid && (mq.size() < 2);
    drn = (mq.size() > 0) && out_ready;
`ifdef PIPE_STAGE_REG_STATS_EN
    if (!rst) begin
      m_stall = 0;
      m_flush = 0;
    end else begin
      if (mq.size() > 0 && !out_ready) m_stall++;
      if (flush && mq.size() > 0) m_flush++;
    end
`endif
    if (!rst) begin
      mq.delete();
      mdata = '0;
    end else if (flush) begin
      mq.delete();
      mdata = '0;
    end else begin
      if (drn) void'(mq.pop_front());
      if (acc) mq.push_back(in_data);
      if (mq.size() > 0) mdata = mq[0];
    end
  endtask

  task automatic model_check(string name);
    chk({name, "_ov"}, 64'(out_valid), 64'(mq.size() > 0));
    chk({name, "_ir"}, 64'(in_ready), 64'(mq.size() < 2));
    chk({name, "_od"}, 64'(out_data), 64'(mdata));
`ifdef PIPE_STAGE_REG_STATS_EN
    chk({name, "_stall"}, 64'(stall_cnt), 64'(m_stall));
    chk({name, "_flush"}, 64'(flush_cnt), 64'(m_flush));
`endif
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  typedef struct {
    logic         rst;
    logic         flush;
    logic         iv;
    logic [W-1:0] d;
    logic         ordy;
    logic         ov;
    logic         ir;
    logic [W-1:0] od;
  } vec_t;

  vec_t tv[15];

  initial begin
    tv[0]  = '{1'b0, 1'b0, 1'b1, 39'h7F_1234_5678, 1'b0, 1'b0, 1'b1, 39'h0};
    tv[1]  = '{1'b0, 1'b0, 1'b1, 39'h7F_1234_5678, 1'b0, 1'b0, 1'b1, 39'h0};
    tv[2]  = '{1'b1, 1'b0, 1'b1, 39'h0AA, 1'b0, 1'b1, 1'b1, 39'h0AA};
    tv[3]  = '{1'b1, 1'b0, 1'b1, 39'h0BB, 1'b0, 1'b1, 1'b0, 39'h0AA};
    tv[4]  = '{1'b1, 1'b0, 1'b1, 39'h0CC, 1'b0, 1'b1, 1'b0, 39'h0AA};
    tv[5]  = '{1'b1, 1'b0, 1'b1, 39'h0CC, 1'b1, 1'b1, 1'b1, 39'h0BB};
    tv[6]  = '{1'b1, 1'b0, 1'b1, 39'h0CC, 1'b1, 1'b1, 1'b1, 39'h0CC};
    tv[7]  = '{1'b1, 1'b0, 1'b0, 39'h0, 1'b1, 1'b0, 1'b1, 39'h0CC};
    tv[8]  = '{1'b1, 1'b0, 1'b1, 39'h0A1, 1'b0, 1'b1, 1'b1, 39'h0A1};
    tv[9]  = '{1'b1, 1'b0, 1'b1, 39'h0B2, 1'b0, 1'b1, 1'b0, 39'h0A1};
    tv[10] = '{1'b1, 1'b1, 1'b1, 39'h0D4, 1'b0, 1'b0, 1'b1, 39'h0};
    tv[11] = '{1'b1, 1'b0, 1'b0, 39'h0, 1'b1, 1'b0, 1'b1, 39'h0};
    tv[12] = '{1'b1, 1'b0, 1'b1, 39'h011, 1'b1, 1'b1, 1'b1, 39'h011};
    tv[13] = '{1'b1, 1'b1, 1'b0, 39'h0, 1'b1, 1'b0, 1'b1, 39'h0};
    tv[14] = '{1'b0, 1'b1, 1'b1, 39'h022, 1'b1, 1'b0, 1'b1, 39'h0};

    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    h_rst = 1'b0; h_flush = 1'b0; h_iv = 1'b0; h_d = '0; h_ordy = 1'b0;
    #2;

    for (int i = 0; i < 15; i++) begin
      rst = tv[i].rst; flush = tv[i].flush; in_valid = tv[i].iv;
      in_data = tv[i].d; out_ready = tv[i].ordy;
      step();
      chk($sformatf("vec%0d_ov", i), 64'(out_valid), 64'(tv[i].ov));
      chk($sformatf("vec%0d_ir", i), 64'(in_ready), 64'(tv[i].ir));
      chk($sformatf("vec%0d_od", i), 64'(out_data), 64'(tv[i].od));
    end

    // Back-to-back streaming, no gaps.
    rst = 1'b1; flush = 1'b0; out_ready = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      in_valid = 1'b1; in_data = W'(i);
      step();
      chk($sformatf("stream%0d_od", i), 64'(out_data), 64'(i));
      chk($sformatf("stream%0d_ov", i), 64'(out_valid), 64'd1);
      chk($sformatf("stream%0d_ir", i), 64'(in_ready), 64'd1);
    end
    in_valid = 1'b0;
    step();
    chk("stream_end_ov", 64'(out_valid), 64'd0);

    // Data-holding flush, then reset together with flush.
    h_rst = 1'b0;
    step();
    chk("hold_rst_od", 64'(h_od), 64'(RV_H));
    chk("hold_rst_ov", 64'(h_ov), 64'd0);
    h_rst = 1'b1; h_iv = 1'b1; h_d = 39'h55;
    step();
    chk("hold_push_od", 64'(h_od), 64'h55);
    h_iv = 1'b0; h_flush = 1'b1;
    step();
    chk("hold_flush_ov", 64'(h_ov), 64'd0);
    chk("hold_flush_ir", 64'(h_ir), 64'd1);
    chk("hold_flush_od", 64'(h_od), 64'h55);
    h_flush = 1'b0; h_iv = 1'b1; h_d = 39'h66;
    step();
    chk("hold_push2_od", 64'(h_od), 64'h66);
    h_iv = 1'b0; h_rst = 1'b0; h_flush = 1'b1;
    step();
    chk("hold_rstflush_od", 64'(h_od), 64'(RV_H));
    chk("hold_rstflush_ov", 64'(h_ov), 64'd0);
    h_rst = 1'b1; h_flush = 1'b0;

`ifdef PIPE_STAGE_REG_STATS_EN
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1; flush = 1'b0;
    step();
    chk("stats_rst_stall", 64'(stall_cnt), 64'd0);
    chk("stats_rst_flush", 64'(flush_cnt), 64'd0);
    rst = 1'b1; in_valid = 1'b1; in_data = 39'h1; out_ready = 1'b0;
    step();
    in_valid = 1'b0;
    repeat (5) step();
    flush = 1'b1; out_ready = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b1; in_data = 39'h2;
    step();
    in_valid = 1'b0; flush = 1'b1;
    step();
    flush = 1'b0;
    chk("stats_stall5", 64'(stall_cnt), 64'd5);
    chk("stats_flush2", 64'(flush_cnt), 64'd2);
`endif

    // Randomized traffic against the FIFO model.
    for (int n = 0; n < 2000; n++) begin
      rst       = ($urandom_range(63) != 0);
      flush     = ($urandom_range(15) == 0);
      in_valid  = $urandom_range(1) == 1;
      in_data   = W'({$urandom(), $urandom()});
      out_ready = ($urandom_range(9) < 7);
      step();
      model_check($sformatf("rand%0d", n));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
